tt_um_hoene_frame_sequencer: RTL and testbench

Frame sequencer for the smart-LED chain. It consumes the filtered single-wire line, i.e. the low-pass-filter output behind the input selector. It decodes pulse-width-coded bits and captures the first NUM_BITS bits of each frame as this node's colour word. All later bits are then forwarded to the next LED, and the captured word is committed when the line stays low for the reset gap.

---
 rtl/tt_um_hoene_frame_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_tt_um_hoene_frame_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tt_um_hoene_frame_sequencer.sv
// Smart-LED frame sequencer: decodes pulse-width bits, keeps the first NUM_BITS, forwards the rest.
// Optional stuck-high abort and sticky error flag: define FRAME_SEQUENCER_STUCK_EN.
module tt_um_hoene_frame_sequencer #(
  parameter int T1H_MIN      = 30,
  parameter int RESET_CYCLES = 2500,
  parameter int NUM_BITS     = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  output logic                dout,
  output logic [NUM_BITS-1:0] color,
  output logic                frame_valid,
  output logic                busy,
  output logic                error
);

  localparam int CW = $clog2(RESET_CYCLES) + 1;
  localparam int BW = $clog2(NUM_BITS + 1);

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] T1H_C    = CW'(T1H_MIN);
  localparam logic [CW-1:0] GAP_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [BW-1:0] BIT_ZERO = {BW{1'b0}};
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BITS_C   = BW'(NUM_BITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIGH    = 2'd1,
    LOW     = 2'd2,
    FORWARD = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                din_q;
  logic [CW-1:0]       hi_cnt_q, hi_cnt_d;
  logic [CW-1:0]       lo_cnt_q, lo_cnt_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [NUM_BITS-1:0] shreg_q, shreg_d;
  logic                dout_q, dout_d;
  logic [NUM_BITS-1:0] color_q, color_d;
  logic                frame_valid_q, frame_valid_d;
  logic                busy_q, busy_d;

  logic                rise_s, fall_s, gap_s, bit_s;
  logic [CW-1:0]       hi_inc_s, lo_inc_s;
  logic [BW-1:0]       bit_nxt_s;

`ifdef FRAME_SEQUENCER_STUCK_EN
  logic                error_q, error_d;
  logic                stuck_s;
`endif

  // Next-state and next-output computation for every register
  always_comb begin
    rise_s    = din & ~din_q;
    fall_s    = ~din & din_q;
    hi_inc_s  = (hi_cnt_q == CNT_MAX) ? hi_cnt_q : hi_cnt_q + CNT_ONE;
    lo_inc_s  = (lo_cnt_q == CNT_MAX) ? lo_cnt_q : lo_cnt_q + CNT_ONE;
    gap_s     = ~din & (lo_cnt_q == GAP_LAST);
    bit_s     = (hi_cnt_q >= T1H_C);
    bit_nxt_s = bit_cnt_q + BIT_ONE;

    state_d       = state_q;
    // The rising-edge sample is itself the first high cycle of the pulse
    hi_cnt_d      = din ? (rise_s ? CNT_ONE : hi_inc_s) : CNT_ZERO;
    lo_cnt_d      = din ? CNT_ZERO : lo_inc_s;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    dout_d        = 1'b0;
    color_d       = color_q;
    frame_valid_d = 1'b0;
`ifdef FRAME_SEQUENCER_STUCK_EN
    error_d       = error_q;
    stuck_s       = din & (hi_cnt_q == GAP_LAST);
`endif

    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d   = HIGH;
          bit_cnt_d = BIT_ZERO;
          shreg_d   = {NUM_BITS{1'b0}};
        end else begin
          state_d   = IDLE;
        end
      end
      HIGH: begin
        if (fall_s) begin
          shreg_d   = {shreg_q[NUM_BITS-2:0], bit_s};
          bit_cnt_d = bit_nxt_s;
          state_d   = (bit_nxt_s == BITS_C) ? FORWARD : LOW;
`ifdef FRAME_SEQUENCER_STUCK_EN
        end else if (stuck_s) begin
          state_d   = IDLE;
          error_d   = 1'b1;
`endif
        end else begin
          state_d   = HIGH;
        end
      end
      LOW: begin
        // A gap here always means a partial frame, so the shift register is dropped
        if (gap_s) begin
          state_d = IDLE;
        end else if (rise_s) begin
          state_d = HIGH;
        end else begin
          state_d = LOW;
        end
      end
      FORWARD: begin
        dout_d = din_q;
        if (gap_s) begin
          state_d = IDLE;
          if (bit_cnt_q == BITS_C) begin
            color_d       = shreg_q;
            frame_valid_d = 1'b1;
          end else begin
            color_d       = color_q;
          end
`ifdef FRAME_SEQUENCER_STUCK_EN
        end else if (stuck_s) begin
          state_d = IDLE;
          dout_d  = 1'b0;
          error_d = 1'b1;
`endif
        end else begin
          state_d = FORWARD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      din_q         <= 1'b0;
      hi_cnt_q      <= CNT_ZERO;
      lo_cnt_q      <= CNT_ZERO;
      bit_cnt_q     <= BIT_ZERO;
      shreg_q       <= {NUM_BITS{1'b0}};
      dout_q        <= 1'b0;
      color_q       <= {NUM_BITS{1'b0}};
      frame_valid_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef FRAME_SEQUENCER_STUCK_EN
      error_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      din_q         <= din;
      hi_cnt_q      <= hi_cnt_d;
      lo_cnt_q      <= lo_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      dout_q        <= dout_d;
      color_q       <= color_d;
      frame_valid_q <= frame_valid_d;
      busy_q        <= busy_d;
`ifdef FRAME_SEQUENCER_STUCK_EN
      error_q       <= error_d;
`endif
    end
  end

  assign dout        = dout_q;
  assign color       = color_q;
  assign frame_valid = frame_valid_q;
  assign busy        = busy_q;
`ifdef FRAME_SEQUENCER_STUCK_EN
  assign error       = error_q;
`else
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_tt_um_hoene_frame_sequencer.sv
// Directed bench for tt_um_hoene_frame_sequencer; stuck-high checks follow FRAME_SEQUENCER_STUCK_EN.
module tb_tt_um_hoene_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        dout;
  logic [23:0] color;
  logic        frame_valid;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int dout_any = 0;
  int dout_hi = 0;
  int mism = 0;
  logic fwd_chk = 1'b0;
  logic din_h1 = 1'b0;
  logic din_h2 = 1'b0;

  tt_um_hoene_frame_sequencer #(
    .T1H_MIN(30), .RESET_CYCLES(2500), .NUM_BITS(24)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dout(dout),
    .color(color), .frame_valid(frame_valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Reference copy of din delayed to match the expected two-cycle forward path
  always @(posedge clk) begin
    din_h1 <= din;
    din_h2 <= din_h1;
  end

  // Mid-cycle monitors for pulses and the forwarded line
  always @(negedge clk) begin
    if (frame_valid) fv_cnt <= fv_cnt + 1;
    if (dout) dout_any <= dout_any + 1;
    if (fwd_chk) begin
      if (dout !== din_h2) mism <= mism + 1;
      if (dout) dout_hi <= dout_hi + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input int hi);
    din = 1'b1;
    repeat (hi) tick();
    din = 1'b0;
    repeat (45) tick();
  endtask

  task automatic send_word(input logic [23:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(w[23-i] ? 40 : 15);
  endtask

  // Last bit already supplied 45 low samples; commit lands on the 2500th
  task automatic gap(input string tag, input logic [23:0] old_c, input logic [23:0] new_c,
                     input logic pulse);
    repeat (2454) tick();
    check({tag, "_busy_pre"}, busy, 1);
    check({tag, "_color_pre"}, color, old_c);
    check({tag, "_fv_pre"}, frame_valid, 0);
    tick();
    check({tag, "_color"}, color, new_c);
    check({tag, "_fv"}, frame_valid, pulse);
    check({tag, "_busy"}, busy, 0);
    tick();
    check({tag, "_fv_after"}, frame_valid, 0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    din = 1'b0;
    repeat (3) tick();
    check("rst_color", color, 0);
    check("rst_fv", frame_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dout", dout, 0);
    check("rst_error", error, 0);
    rst_n = 1'b1;

    // Idle line longer than the gap: nothing happens
    repeat (2600) tick();
    check("idle_busy", busy, 0);
    check("idle_fv_cnt", fv_cnt, 0);

    // Single 24-bit frame
    din = 1'b1;
    tick();
    check("t1_busy_rise", busy, 1);
    repeat (39) tick();
    din = 1'b0;
    repeat (45) tick();
    send_word(24'h4B8678, 23);
    gap("t1", 24'h000000, 24'hA5C33C, 1'b1);
    check("t1_fv_cnt", fv_cnt, 1);
    check("t1_dout_quiet", dout_any, 0);

    // Partial frame is discarded
    send_word(24'h2AA000, 10);
    gap("part", 24'hA5C33C, 24'hA5C33C, 1'b0);
    check("part_fv_cnt", fv_cnt, 1);
    check("part_dout_quiet", dout_any, 0);

    // 48-bit frame: second half forwarded
    send_word(24'h123456, 24);
    fwd_chk = 1'b1;
    send_word(24'hFFFFFF, 24);
    fwd_chk = 1'b0;
    gap("t2", 24'hA5C33C, 24'h123456, 1'b1);
    check("t2_fv_cnt", fv_cnt, 2);
    check("t2_fwd_mism", mism, 0);
    check("t2_fwd_hi", dout_hi, 960);
    check("t2_dout_idle", dout, 0);

    // Reset in the middle of a frame, then a full frame
    send_word(24'hABCDEF, 12);
    rst_n = 1'b0;
    tick();
    check("mrst_color", color, 0);
    check("mrst_busy", busy, 0);
    check("mrst_fv", frame_valid, 0);
    check("mrst_dout", dout, 0);
    rst_n = 1'b1;
    tick();
    send_word(24'h0F0F0F, 24);
    gap("t5", 24'h000000, 24'h0F0F0F, 1'b1);
    check("t5_fv_cnt", fv_cnt, 3);

    // Line stuck high mid-frame
    for (int i = 0; i < 5; i++) send_bit(15);
    din = 1'b1;
    repeat (2600) tick();
`ifdef FRAME_SEQUENCER_STUCK_EN
    check("stuck_error", error, 1);
    check("stuck_busy", busy, 0);
`else
    check("stuck_error", error, 0);
    check("stuck_busy", busy, 1);
`endif
    check("stuck_dout", dout, 0);
    din = 1'b0;
    repeat (2600) tick();
    check("stuck_end_busy", busy, 0);
    check("stuck_end_color", color, 24'h0F0F0F);
    check("stuck_end_fv_cnt", fv_cnt, 3);

    // Decode threshold: 30 high cycles is a 1
    send_bit(30);
    for (int i = 0; i < 23; i++) send_bit(15);
    gap("thr30", 24'h0F0F0F, 24'h800000, 1'b1);

    // 29 high cycles is a 0
    send_bit(29);
    for (int i = 0; i < 23; i++) send_bit(15);
    gap("thr29", 24'h800000, 24'h000000, 1'b1);
    tick();
    check("end_fv_cnt", fv_cnt, 5);
`ifdef FRAME_SEQUENCER_STUCK_EN
    check("end_error_sticky", error, 1);
`else
    check("end_error", error, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
